// File: rtl/uart_tx_sequencer.sv
// UART transmitter: one-byte holding register feeding a start/data/stop shifter, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_sequencer #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       clr_ovr,
  output logic       tx,
  output logic       txrdy,
  output logic       busy,
  output logic       done,
  output logic       ovr
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      thr_q, thr_d;
  logic            full_q, full_d;
  logic            ovr_q, ovr_d;
  logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic baud_tick;
  logic load;

  assign baud_tick = (state_q != S_IDLE) && (baud_q == BAUD_LAST);
  // THR moves into the shifter either from idle or on the final stop-bit clock (zero-gap chaining).
  assign load      = full_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_tick));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (full_q) state_d = S_START;
      S_START:  if (baud_tick) state_d = S_DATA;
      S_DATA: begin
        if (baud_tick && (bitcnt_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (baud_tick) state_d = S_STOP;
`endif
      S_STOP:   if (baud_tick) state_d = full_q ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    baud_d   = (state_q == S_IDLE || baud_tick) ? '0 : baud_q + CW'(1);
    bitcnt_d = '0;
    if (state_q == S_DATA) begin
      bitcnt_d = baud_tick ? bitcnt_q + 3'd1 : bitcnt_q;
    end

    shift_d = shift_q;
    if (load) begin
      shift_d = thr_q;
    end else if ((state_q == S_DATA) && baud_tick) begin
      shift_d = {1'b0, shift_q[7:1]};
    end

    thr_d  = thr_q;
    full_d = full_q;
    if (load) begin
      full_d = 1'b0;
    end
    if (wr && !full_q) begin
      thr_d  = din;
      full_d = 1'b1;
    end

    ovr_d = ovr_q;
    if (wr && full_q) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end

`ifdef UART_TX_PARITY_EN
    par_d = load ? ^thr_q : par_q;
`endif
  end

  // Line level is computed from the next state so tx flips on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_STOP) && baud_tick;
    txrdy = !full_q;
    tx    = tx_q;
    ovr   = ovr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      thr_q    <= '0;
      full_q   <= 1'b0;
      ovr_q    <= 1'b0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      thr_q    <= thr_d;
      full_q   <= full_d;
      ovr_q    <= ovr_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer at BAUD_DIV=4; frame length follows UART_TX_PARITY_EN.
module tb_uart_tx_sequencer;

  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx, txrdy, busy, done, ovr;

  int checks = 0;
  int errors = 0;
  int frames_rx = 0;
  int b2b_cnt = 0;
  int done_cnt = 0;
  logic [7:0] sb[$];

  uart_tx_sequencer #(.BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .wr(wr), .din(din), .clr_ovr(clr_ovr),
    .tx(tx), .txrdy(txrdy), .busy(busy), .done(done), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic clr);
    wr = 1'b1; din = b; clr_ovr = clr;
    @(posedge clk); #1;
    wr = 1'b0; clr_ovr = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int target;
    int t;
    target = frames_rx + n;
    t = 0;
    while (frames_rx < target && t < 200 * n) begin
      @(posedge clk);
      t++;
    end
    chk("frame_wait_in_time", (frames_rx >= target) ? 1 : 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || txrdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk(name, bad, 0);
  endtask

  always @(negedge clk) if (!reset && done === 1'b1) done_cnt++;

  // Monitor: decodes each frame from the line and pops the expected byte.
  initial begin : monitor
    logic          have;
    logic          aborted;
    logic [NB-1:0] bits;
    logic [7:0]    exp_b;
    int            unstable, busy_bad, done_bad;
    have = 1'b0;
    forever begin
      if (!have) @(negedge clk);
      have = 1'b0;
      if (reset) continue;
      if (done === 1'b1) chk("done_outside_frame", done, 0);
      if (tx === 1'b0) begin
        bits = '0; unstable = 0; busy_bad = 0; done_bad = 0; aborted = 1'b0;
        for (int b = 0; b < NB && !aborted; b++) begin
          for (int c = 0; c < BD; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (reset) begin
              aborted = 1'b1;
              break;
            end
            if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) unstable++;
            if (busy !== 1'b1) busy_bad++;
            if (done !== ((b == NB - 1 && c == BD - 1) ? 1'b1 : 1'b0)) done_bad++;
          end
        end
        if (!aborted) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got 0x%0h expected no frame", bits[8:1]);
          end else begin
            exp_b = sb.pop_front();
            chk("frame_data", bits[8:1], exp_b);
`ifdef UART_TX_PARITY_EN
            chk("parity_bit", bits[9], ^exp_b);
`endif
          end
          chk("stop_bit", bits[NB-1], 1);
          chk("bit_stable", unstable, 0);
          chk("busy_in_frame", busy_bad, 0);
          chk("done_position", done_bad, 0);
          frames_rx++;
          @(negedge clk);
          if (!reset) begin
            chk("busy_after_frame", busy, (tx === 1'b0) ? 1 : 0);
            if (tx === 1'b0) b2b_cnt++;
          end
          have = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stimulus
    int b0, d0;
    repeat (2) @(posedge clk); #1;
    chk("reset_tx", tx, 1);
    chk("reset_txrdy", txrdy, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ovr", ovr, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    idle_cycles("idle_50_bad_cycles", 50);
    chk("idle_ovr", ovr, 0);

    // Single byte with start-of-frame latency
    wr_byte(8'hA5, 1'b0); sb.push_back(8'hA5);
    chk("n_txrdy", txrdy, 0);
    chk("n_busy", busy, 0);
    chk("n_tx", tx, 1);
    @(posedge clk); #1;
    chk("n2_tx", tx, 0);
    chk("n2_busy", busy, 1);
    chk("n2_txrdy", txrdy, 1);
    d0 = done_cnt;
    wait_frames(1);
    chk("single_done_pulses", done_cnt - d0, 1);

    // Back-to-back: second write at N+2
    b0 = b2b_cnt; d0 = done_cnt;
    wr_byte(8'h55, 1'b0); sb.push_back(8'h55);
    @(posedge clk); #1;
    wr_byte(8'h0F, 1'b0); sb.push_back(8'h0F);
    chk("b2b_second_accepted_txrdy", txrdy, 0);
    wait_frames(2);
    chk("b2b_zero_gap", b2b_cnt - b0, 1);
    chk("b2b_done_pulses", done_cnt - d0, 2);

    // Overrun: 11 shifting, 22 held, 33 dropped
    wr_byte(8'h11, 1'b0); sb.push_back(8'h11);
    @(posedge clk); #1;
    wr_byte(8'h22, 1'b0); sb.push_back(8'h22);
    chk("ovr_before", ovr, 0);
    wr_byte(8'h33, 1'b0);
    chk("ovr_set", ovr, 1);
    repeat (3) @(posedge clk); #1;
    chk("ovr_sticky", ovr, 1);
    wr_byte(8'h66, 1'b1);
    chk("ovr_set_wins_over_clr", ovr, 1);
    wait_frames(2);
    chk("ovr_after_frames", ovr, 1);
    clr_ovr = 1'b1; @(posedge clk); #1; clr_ovr = 1'b0;
    chk("ovr_cleared", ovr, 0);

    // Reset during DATA bit 3 of FF, with 99 waiting in THR
    wr_byte(8'hFF, 1'b0);
    @(posedge clk); #1;
    wr_byte(8'h99, 1'b0);
    chk("thr_full_before_reset", txrdy, 0);
    repeat (16) @(posedge clk); #1;
    chk("ff_bit3_line", tx, 1);
    chk("ff_bit3_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_txrdy", txrdy, 1);
    reset = 1'b0;
    idle_cycles("abort_thr_discarded", 30);
    wr_byte(8'h81, 1'b0); sb.push_back(8'h81);
    wait_frames(1);

    // Parity-relevant bytes (parity 1 and 0)
    wr_byte(8'h07, 1'b0); sb.push_back(8'h07);
    wait_frames(1);
    wr_byte(8'h03, 1'b0); sb.push_back(8'h03);
    wait_frames(1);

    repeat (5) @(posedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("frames_total", frames_rx, 8);
    chk("done_total", done_cnt, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
